rs_array: RTL and testbench

- Parametrised reservation-station bank with NUM_ENTRIES entries, sitting between Issue and Execute. One bank feeds one functional unit.
- Accepts one allocation per cycle through a valid/ready handshake.
- Wakes pending operands from NUM_CDB common data buses.
- Each cycle, selects the oldest entry whose operands are both ready and issues it to the FU through a valid/ready handshake.

---
 rtl/rs_array_if.sv | 44 ++++
 rtl/rs_array.sv | 142 ++++++++++++++
 tb/tb_rs_array.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/rs_array_if.sv
// rs_array_if: allocation, CDB wakeup and issue bus of one reservation-station bank.
interface rs_array_if #(
    parameter int NUM_ENTRIES = 4,
    parameter int NUM_CDB     = 1,
    parameter int XLEN        = 32,
    parameter int TAG_W       = 4,
    parameter int OP_W        = 5,
    parameter int BR_W        = 3
);
    localparam int CW = $clog2(NUM_ENTRIES + 1);
    logic                     alloc_valid;
    logic                     alloc_ready;
    logic [OP_W-1:0]          alloc_op;
    logic [BR_W-1:0]          alloc_br;
    logic                     alloc_load;
    logic [TAG_W-1:0]         alloc_rob;
    logic [TAG_W-1:0]         alloc_qj;
    logic [TAG_W-1:0]         alloc_qk;
    logic [XLEN-1:0]          alloc_vj;
    logic [XLEN-1:0]          alloc_vk;
    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
    logic [NUM_CDB*XLEN-1:0]  cdb_result;
    logic [NUM_CDB-1:0]       cdb_load_step1;
    logic                     issue_valid;
    logic                     issue_ready;
    logic [OP_W-1:0]          issue_op;
    logic [BR_W-1:0]          issue_br;
    logic                     issue_load;
    logic [TAG_W-1:0]         issue_rob;
    logic [XLEN-1:0]          issue_rs1;
    logic [XLEN-1:0]          issue_rs2;
    logic [CW-1:0]            free_count;
    modport master (
        output alloc_valid, alloc_op, alloc_br, alloc_load, alloc_rob, alloc_qj, alloc_qk, alloc_vj, alloc_vk,
        output cdb_valid, cdb_tag, cdb_result, cdb_load_step1, issue_ready,
        input  alloc_ready, issue_valid, issue_op, issue_br, issue_load, issue_rob, issue_rs1, issue_rs2, free_count
    );
    modport slave (
        input  alloc_valid, alloc_op, alloc_br, alloc_load, alloc_rob, alloc_qj, alloc_qk, alloc_vj, alloc_vk,
        input  cdb_valid, cdb_tag, cdb_result, cdb_load_step1, issue_ready,
        output alloc_ready, issue_valid, issue_op, issue_br, issue_load, issue_rob, issue_rs1, issue_rs2, free_count
    );
endinterface

// File: rtl/rs_array.sv
// rs_array: reservation-station bank with CDB wakeup and oldest-ready issue select.
// Define RS_PERF_CNT_EN to add the perf_issue_cnt / perf_full_cnt counters.
module rs_array #(
    parameter int NUM_ENTRIES = 4,
    parameter int NUM_CDB     = 1,
    parameter int XLEN        = 32,
    parameter int TAG_W       = 4,
    parameter int OP_W        = 5,
    parameter int BR_W        = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
`ifdef RS_PERF_CNT_EN
    output logic [31:0] perf_issue_cnt,
    output logic [31:0] perf_full_cnt,
`endif
    rs_array_if.slave   bus
);
    localparam int N  = NUM_ENTRIES;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N + 1);
    logic [N-1:0]             valid, ready, grant;
    logic [OP_W-1:0]          op   [N];
    logic [BR_W-1:0]          br   [N];
    logic                     ld   [N];
    logic [TAG_W-1:0]         rob  [N];
    logic [TAG_W-1:0]         qj   [N];
    logic [TAG_W-1:0]         qk   [N];
    logic [XLEN-1:0]          vj   [N];
    logic [XLEN-1:0]          vk   [N];
    logic [N-1:0]             older[N];
    logic [XLEN:0]            wj   [N+1];
    logic [XLEN:0]            wk   [N+1];
    logic [CW-1:0]            free_count;
    logic [IW-1:0]            aidx, sidx;
    logic                     alloc_ready, alloc_fire, issue_fire;
    logic [NUM_CDB-1:0]       cv, cl;
    logic [NUM_CDB*TAG_W-1:0] ct;
    logic [NUM_CDB*XLEN-1:0]  cr;
    assign cv = bus.cdb_valid;
    assign cl = bus.cdb_load_step1;
    assign ct = bus.cdb_tag;
    assign cr = bus.cdb_result;
    // {hit, result}; scanning from the top lets the lowest matching port win
    function automatic logic [XLEN:0] wake(input logic [TAG_W-1:0] q);
        wake = '0;
        for (int p = NUM_CDB - 1; p >= 0; p--)
            if (q != '0 && cv[p] && !cl[p] && ct[p*TAG_W +: TAG_W] == q) wake = {1'b1, cr[p*XLEN +: XLEN]};
    endfunction
    always_comb begin
        aidx = '0;
        sidx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            ready[i] = valid[i] && qj[i] == '0 && qk[i] == '0;
            if (!valid[i]) aidx = IW'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
            grant[i] = ready[i];
            for (int j = 0; j < N; j++) if (ready[j] && older[j][i]) grant[i] = 1'b0;
            if (grant[i]) sidx = IW'(i);
        end
    end
    // slot N carries the same-cycle bypass for the allocating instruction
    always_comb begin
        for (int i = 0; i < N; i++) begin
            wj[i] = wake(qj[i]);
            wk[i] = wake(qk[i]);
        end
        wj[N] = wake(bus.alloc_qj);
        wk[N] = wake(bus.alloc_qk);
    end
    assign alloc_ready = free_count != '0 && !flush;
    assign alloc_fire  = bus.alloc_valid && alloc_ready;
    assign issue_fire  = |ready && bus.issue_ready;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid      <= '0;
            free_count <= CW'(N);
            for (int i = 0; i < N; i++) begin
                op[i]    <= '0;
                br[i]    <= '0;
                ld[i]    <= 1'b0;
                rob[i]   <= '0;
                qj[i]    <= '0;
                qk[i]    <= '0;
                vj[i]    <= '0;
                vk[i]    <= '0;
                older[i] <= '0;
            end
        end else if (flush) begin
            valid      <= '0;
            free_count <= CW'(N);
        end else begin
            free_count <= free_count + CW'(issue_fire) - CW'(alloc_fire);
            for (int i = 0; i < N; i++) begin
                if (valid[i] && wj[i][XLEN]) begin
                    qj[i] <= '0;
                    vj[i] <= wj[i][XLEN-1:0];
                end
                if (valid[i] && wk[i][XLEN]) begin
                    qk[i] <= '0;
                    vk[i] <= wk[i][XLEN-1:0];
                end
                if (issue_fire && sidx == IW'(i)) valid[i] <= 1'b0;
                if (alloc_fire && aidx == IW'(i)) begin
                    valid[i] <= 1'b1;
                    op[i]    <= bus.alloc_op;
                    br[i]    <= bus.alloc_br;
                    ld[i]    <= bus.alloc_load;
                    rob[i]   <= bus.alloc_rob;
                    qj[i]    <= wj[N][XLEN] ? '0 : bus.alloc_qj;
                    vj[i]    <= wj[N][XLEN] ? wj[N][XLEN-1:0] : bus.alloc_vj;
                    qk[i]    <= wk[N][XLEN] ? '0 : bus.alloc_qk;
                    vk[i]    <= wk[N][XLEN] ? wk[N][XLEN-1:0] : bus.alloc_vk;
                    older[i] <= '0;
                end
                for (int j = 0; j < N; j++) if (alloc_fire && aidx == IW'(j)) older[i][j] <= valid[i];
            end
        end
    end
    assign bus.alloc_ready = alloc_ready;
    assign bus.free_count  = free_count;
    assign bus.issue_valid = |ready;
    assign bus.issue_op    = |ready ? op[sidx]  : '0;
    assign bus.issue_br    = |ready ? br[sidx]  : '0;
    assign bus.issue_load  = |ready ? ld[sidx]  : 1'b0;
    assign bus.issue_rob   = |ready ? rob[sidx] : '0;
    assign bus.issue_rs1   = |ready ? vj[sidx]  : '0;
    assign bus.issue_rs2   = |ready ? vk[sidx]  : '0;
`ifdef RS_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_issue_cnt <= '0;
            perf_full_cnt  <= '0;
        end else begin
            perf_issue_cnt <= perf_issue_cnt + 32'(issue_fire);
            perf_full_cnt  <= perf_full_cnt + 32'(bus.alloc_valid && !alloc_ready);
        end
    end
`endif
endmodule

// File: tb/tb_rs_array.sv
// tb_rs_array: directed and random stimulus against an allocation-ordered queue model.
module tb_rs_array;
    localparam int N  = 4;
    localparam int NC = 2;
    typedef struct packed {
        logic [4:0]  op;
        logic [2:0]  br;
        logic        ld;
        logic [3:0]  rob;
        logic [3:0]  qj;
        logic [3:0]  qk;
        logic [31:0] vj;
        logic [31:0] vk;
    } ent_t;
    logic clk = 1'b0, reset = 1'b1, flush = 1'b0;
    int   checks = 0, fails = 0;
    ent_t q[$];
    always #5 clk = ~clk;
    rs_array_if #(.NUM_ENTRIES(N), .NUM_CDB(NC)) bus ();
`ifdef RS_PERF_CNT_EN
    logic [31:0] perf_issue_cnt, perf_full_cnt;
`endif
    rs_array #(.NUM_ENTRIES(N), .NUM_CDB(NC)) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
`ifdef RS_PERF_CNT_EN
        .perf_issue_cnt(perf_issue_cnt),
        .perf_full_cnt(perf_full_cnt),
`endif
        .bus(bus)
    );
    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, o, e);
        end
    endtask
    // first valid, non-load_step1 port carrying tag t supplies the value
    function automatic logic [32:0] wk(input logic [3:0] t);
        for (int p = 0; p < NC; p++)
            if (t != 4'd0 && bus.cdb_valid[p] && !bus.cdb_load_step1[p] && bus.cdb_tag[p*4 +: 4] == t)
                return {1'b1, bus.cdb_result[p*32 +: 32]};
        return '0;
    endfunction
    task automatic idle();
        flush = 1'b0;
        bus.alloc_valid = 1'b0;
        bus.alloc_op = '0;
        bus.alloc_br = '0;
        bus.alloc_load = 1'b0;
        bus.alloc_rob = '0;
        bus.alloc_qj = '0;
        bus.alloc_qk = '0;
        bus.alloc_vj = '0;
        bus.alloc_vk = '0;
        bus.cdb_valid = '0;
        bus.cdb_tag = '0;
        bus.cdb_result = '0;
        bus.cdb_load_step1 = '0;
    endtask
    task automatic put(input logic [3:0] rob, input logic [3:0] qj, input logic [31:0] vj,
                       input logic [3:0] qk, input logic [31:0] vk);
        bus.alloc_valid = 1'b1;
        bus.alloc_op = 5'($urandom);
        bus.alloc_br = 3'($urandom);
        bus.alloc_load = 1'($urandom);
        bus.alloc_rob = rob;
        bus.alloc_qj = qj;
        bus.alloc_vj = vj;
        bus.alloc_qk = qk;
        bus.alloc_vk = vk;
    endtask
    task automatic cdb(input int p, input logic [3:0] t, input logic [31:0] r, input logic ls);
        bus.cdb_valid[p] = 1'b1;
        bus.cdb_tag[p*4 +: 4] = t;
        bus.cdb_result[p*32 +: 32] = r;
        bus.cdb_load_step1[p] = ls;
    endtask
    // called on a falling edge: compare against the model, advance it past the next rising edge
    task automatic cyc();
        int s;
        ent_t e, a;
        logic [32:0] w;
        logic fire_a;
        #1;
        s = -1;
        foreach (q[k]) if (s < 0 && q[k].qj == 4'd0 && q[k].qk == 4'd0) s = k;
        e = (s >= 0) ? q[s] : '0;
        chk("issue_valid", 64'(bus.issue_valid), 64'(s >= 0));
        chk("issue_rob", 64'(bus.issue_rob), 64'(e.rob));
        chk("issue_op", 64'(bus.issue_op), 64'(e.op));
        chk("issue_br", 64'(bus.issue_br), 64'(e.br));
        chk("issue_load", 64'(bus.issue_load), 64'(e.ld));
        chk("issue_rs1", 64'(bus.issue_rs1), 64'(e.vj));
        chk("issue_rs2", 64'(bus.issue_rs2), 64'(e.vk));
        chk("alloc_ready", 64'(bus.alloc_ready), 64'(q.size() < N && !flush));
        chk("free_count", 64'(bus.free_count), 64'(N - q.size()));
        fire_a = bus.alloc_valid && q.size() < N;
        if (flush) q.delete();
        else begin
            if (s >= 0 && bus.issue_ready) q.delete(s);
            foreach (q[k]) begin
                a = q[k];
                w = wk(a.qj);
                if (w[32]) begin a.qj = 4'd0; a.vj = w[31:0]; end
                w = wk(a.qk);
                if (w[32]) begin a.qk = 4'd0; a.vk = w[31:0]; end
                q[k] = a;
            end
            if (fire_a) begin
                a.op = bus.alloc_op;
                a.br = bus.alloc_br;
                a.ld = bus.alloc_load;
                a.rob = bus.alloc_rob;
                w = wk(bus.alloc_qj);
                a.qj = w[32] ? 4'd0 : bus.alloc_qj;
                a.vj = w[32] ? w[31:0] : bus.alloc_vj;
                w = wk(bus.alloc_qk);
                a.qk = w[32] ? 4'd0 : bus.alloc_qk;
                a.vk = w[32] ? w[31:0] : bus.alloc_vk;
                q.push_back(a);
            end
        end
        @(negedge clk);
    endtask
    initial begin
        idle();
        bus.issue_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
        chk("rst_free_count", 64'(bus.free_count), 64'(N));
        chk("rst_alloc_ready", 64'(bus.alloc_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        bus.issue_ready = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            put(4'(r), 4'd0, 32'(r * 16), 4'd0, 32'(r * 256));
            cyc();
            chk("order_rob", 64'(bus.issue_rob), 64'(r));
        end
        idle();
        repeat (4) cyc();
        chk("drained_free", 64'(bus.free_count), 64'(N));
        bus.issue_ready = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            put(4'(r), 4'd0, $urandom, 4'd0, $urandom);
            cyc();
        end
        put(4'd5, 4'd0, 32'h5555, 4'd0, 32'h6666);
        chk("full_ready", 64'(bus.alloc_ready), 64'd0);
        cyc();
        bus.issue_ready = 1'b1;
        cyc();
        bus.issue_ready = 1'b0;
        chk("freed_ready", 64'(bus.alloc_ready), 64'd1);
        cyc();
        chk("refilled_free", 64'(bus.free_count), 64'd0);
        idle();
        bus.issue_ready = 1'b1;
        repeat (5) cyc();
        put(4'd2, 4'd5, 32'd0, 4'd0, 32'h77);
        cyc();
        idle();
        cdb(0, 4'd5, 32'hDEADBEEF, 1'b1);
        cyc();
        chk("step1_no_wake", 64'(bus.issue_valid), 64'd0);
        idle();
        cdb(0, 4'd5, 32'hDEADBEEF, 1'b0);
        cyc();
        chk("woken_valid", 64'(bus.issue_valid), 64'd1);
        chk("woken_rs1", 64'(bus.issue_rs1), 64'hDEADBEEF);
        idle();
        cyc();
        put(4'd6, 4'd0, 32'd11, 4'd7, 32'd0);
        cdb(1, 4'd7, 32'h1234, 1'b0);
        cyc();
        chk("bypass_rs2", 64'(bus.issue_rs2), 64'h1234);
        idle();
        cyc();
        put(4'd3, 4'd6, 32'd0, 4'd0, 32'd3);
        cyc();
        put(4'd4, 4'd0, 32'd4, 4'd0, 32'd4);
        cyc();
        chk("young_first", 64'(bus.issue_rob), 64'd4);
        idle();
        bus.issue_ready = 1'b0;
        cdb(0, 4'd6, 32'h55, 1'b0);
        cyc();
        chk("old_preempts", 64'(bus.issue_rob), 64'd3);
        idle();
        bus.issue_ready = 1'b1;
        repeat (2) cyc();
        bus.issue_ready = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            put(4'(r + 8), 4'd0, 32'd0, 4'd0, 32'd0);
            cyc();
        end
        put(4'd12, 4'd0, 32'd0, 4'd0, 32'd0);
        flush = 1'b1;
        cyc();
        chk("flush_free", 64'(bus.free_count), 64'(N));
        chk("flush_valid", 64'(bus.issue_valid), 64'd0);
        idle();
        repeat (2) begin
            put(4'd13, 4'd0, 32'd1, 4'd0, 32'd2);
            cyc();
        end
        idle();
        #3 reset = 1'b1;
        #1;
        chk("async_issue_valid", 64'(bus.issue_valid), 64'd0);
        chk("async_free", 64'(bus.free_count), 64'(N));
        chk("async_ready", 64'(bus.alloc_ready), 64'd1);
        chk("async_rob", 64'(bus.issue_rob), 64'd0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (3000) begin
            idle();
            if ($urandom_range(0, 99) < 60)
                put(4'($urandom_range(1, 15)),
                    $urandom_range(0, 1) ? 4'($urandom_range(1, 7)) : 4'd0, $urandom,
                    $urandom_range(0, 1) ? 4'($urandom_range(1, 7)) : 4'd0, $urandom);
            for (int p = 0; p < NC; p++)
                if ($urandom_range(0, 1) == 1) cdb(p, 4'($urandom_range(1, 7)), $urandom, $urandom_range(0, 4) == 0);
            bus.issue_ready = $urandom_range(0, 9) < 7;
            flush = $urandom_range(0, 49) == 0;
            cyc();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
